spi_slave_link: RTL and testbench

Oversampled SPI mode-0 slave running entirely in the master clock domain. It sits between the board SPI pins and the VideoCore command decoder. It synchronises the SPI pins, assembles MSB-first bytes and buffers them in a small FIFO toward the decoder. It shifts a status byte back on MISO.

---
 rtl/spi_link_pkg.sv | 29 ++
 rtl/byte_fifo.sv | 65 ++++++
 rtl/spi_slave_link.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_link.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// Shared types and constants for the SPI slave link.
//   STATUS_OVERFLOW_BIT : bit of the status byte replaced by the overflow flag
//   SCLK_MIN_DIV        : slowest master/SCLK ratio the oversampler tolerates
//   fifo_entry_t        : {first, data[7:0]} byte FIFO entry
//   link_state_t        : frame FSM states
//   status_byte()       : status byte with the overflow bit substituted
package spi_link_pkg;

    localparam int STATUS_OVERFLOW_BIT = 7;
    localparam int SCLK_MIN_DIV        = 8;

    typedef struct packed {
        logic       first;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } link_state_t;

    function automatic logic [7:0] status_byte(input logic ovf, input logic [7:0] status);
        logic [7:0] b;
        b = status;
        b[STATUS_OVERFLOW_BIT] = ovf;
        return b;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO of fifo_entry_t with a registered head output.
//   clk, rst : clock, async active-high reset
//   wr_en    : push request (wr_data)
//   rd_en    : pop request; ignored while empty
//   rd_data  : registered head entry, valid while !empty
//   empty    : no entries
//   drop     : push request refused because the FIFO is full (no pop that cycle)
module byte_fifo
    import spi_link_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  fifo_entry_t wr_data,
    input  logic        rd_en,
    output fifo_entry_t rd_data,
    output logic        empty,
    output logic        drop
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [PTR_W:0]   count, count_nxt;
    logic             full, pop, push, bypass;
    fifo_entry_t      head_nxt;

    always_comb begin
        full       = (count == FULL_CNT);
        empty      = (count == '0);
        pop        = rd_en & ~empty;
        // a pop in the same cycle frees the slot the push needs
        push       = wr_en & (~full | pop);
        drop       = wr_en & ~push;
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        // the written entry becomes head when nothing else remains ahead of it
        bypass     = push & (count == (PTR_W+1)'(pop));
        head_nxt   = bypass ? wr_data : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            // head holds its last value once drained
            if ((push | pop) && count_nxt != '0) rd_data <= head_nxt;
        end
    end

endmodule

// File: rtl/spi_slave_link.sv
// Oversampled SPI mode-0 slave in the master clock domain. Receives MSB-first
// bytes into a FIFO toward the command decoder and returns a status byte on MISO.
//   i_master_clk, i_reset                : clock, async active-high reset
//   i_spi_cs_n, i_spi_clk, i_spi_mosi    : raw SPI pins (asynchronous)
//   o_spi_miso                           : status bit out, MSB first
//   i_status                             : status byte; bit 7 replaced by overflow
//   o_data, o_first, o_valid, i_ready    : FIFO head handshake
//   o_frame_end                          : one-cycle pulse at synchronised CS rise
//   o_overflow                           : sticky, a byte was dropped
//   o_active                             : frame in progress
module spi_slave_link
    import spi_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_master_clk,
    input  logic       i_reset,
    input  logic       i_spi_cs_n,
    input  logic       i_spi_clk,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    input  logic [7:0] i_status,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_first,
    input  logic       i_ready,
    output logic       o_frame_end,
    output logic       o_overflow,
    output logic       o_active
);

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_d, sclk_d;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   armed;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

    link_state_t            state, state_nxt;
    logic                   frame_start, frame_stop, bit_rise, bit_fall;

    logic [2:0]             bit_cnt, fall_cnt;
    logic [6:0]             shift_in;
    logic [7:0]             shift_out;
    logic                   first_mark;
    logic                   push_q;
    fifo_entry_t            push_entry;
    logic                   ovf_clr;
    logic                   fifo_empty, fifo_drop;
    fifo_entry_t            head;

    // ---------------- synchronisers + edge detect ----------------
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b1;
            vld_pipe  <= '0;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   i_spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
            // vld_pipe fills once the reset values have flushed out of the
            // chain; only then is a high CS real, and only a real high CS
            // arms frame detection (a frame spanning reset is ignored)
            vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            armed     <= armed | (vld_pipe[SYNC_STAGES] & cs_s);
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // ---------------- frame FSM ----------------
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (armed && cs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cs_rise)          state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        frame_stop  = 1'b0;
        bit_rise    = 1'b0;
        bit_fall    = 1'b0;
        o_active    = 1'b0;
        case (state)
            ST_IDLE: frame_start = armed & cs_fall;
            ST_SHIFT: begin
                o_active   = 1'b1;
                frame_stop = cs_rise;
                bit_rise   = sclk_rise & ~cs_rise;
                bit_fall   = sclk_fall & ~cs_rise;
            end
            default: ;
        endcase
    end

    // ---------------- shift registers ----------------
    // overflow is released at frame start only if the consumer has drained
    assign ovf_clr = frame_start & fifo_empty;

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            bit_cnt     <= '0;
            fall_cnt    <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            first_mark  <= 1'b0;
            push_q      <= 1'b0;
            push_entry  <= '0;
            o_frame_end <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_frame_end <= frame_stop;
            // byte completion is registered once before the FIFO
            push_q      <= bit_rise & (bit_cnt == 3'd7);
            push_entry  <= '{first: first_mark, data: {shift_in, mosi_s}};

            if (fifo_drop)    o_overflow <= 1'b1;
            else if (ovf_clr) o_overflow <= 1'b0;

            if (frame_start) begin
                bit_cnt    <= '0;
                fall_cnt   <= '0;
                first_mark <= 1'b1;
                shift_out  <= status_byte(o_overflow & ~ovf_clr, i_status);
            end else if (frame_stop) begin
                // partial byte discarded
                bit_cnt  <= '0;
                fall_cnt <= '0;
            end else begin
                if (bit_rise) begin
                    shift_in <= {shift_in[5:0], mosi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) first_mark <= 1'b0;
                end
                if (bit_fall) begin
                    fall_cnt <= fall_cnt + 3'd1;
                    if (fall_cnt == 3'd7) shift_out <= status_byte(o_overflow, i_status);
                    else                  shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign o_spi_miso = shift_out[7];

    // ---------------- output FIFO ----------------
    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_master_clk),
        .rst     (i_reset),
        .wr_en   (push_q),
        .wr_data (push_entry),
        .rd_en   (i_ready),
        .rd_data (head),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    assign o_valid = ~fifo_empty;
    assign o_data  = head.data;
    assign o_first = head.first;

endmodule

// File: tb/tb_spi_slave_link.sv
// Directed/randomised bench for spi_slave_link: drives SPI mode-0 frames at
// master/8 and compares popped bytes, MISO bytes and flags with a queue model.
module tb_spi_slave_link;

    localparam int DEPTH = 8;
    localparam int PH    = 4;   // master cycles per SCLK phase

    logic       clk = 1'b0;
    logic       rst, cs_n, sclk, mosi, rdy;
    logic [7:0] st;
    logic       o_spi_miso, o_valid, o_first, o_frame_end, o_overflow, o_active;
    logic [7:0] o_data;

    int n_chk  = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int exp_fe = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       m_ovf    = 1'b0;
    logic       m_first  = 1'b0;
    logic       in_frame = 1'b0;
    logic       chk_miso = 1'b1;
    logic [7:0] miso_exp = 8'h00;

    always #5 clk = ~clk;

    spi_slave_link #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .i_master_clk (clk),
        .i_reset      (rst),
        .i_spi_cs_n   (cs_n),
        .i_spi_clk    (sclk),
        .i_spi_mosi   (mosi),
        .o_spi_miso   (o_spi_miso),
        .i_status     (st),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_first      (o_first),
        .i_ready      (rdy),
        .o_frame_end  (o_frame_end),
        .o_overflow   (o_overflow),
        .o_active     (o_active)
    );

    // record every pop and frame-end pulse, sampled mid low phase
    always @(negedge clk) begin
        #2;
        if (o_valid && rdy) got_q.push_back({o_first, o_data});
        if (o_frame_end) fe_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: no finish within %0d ns", 500000);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int occ();
        return exp_q.size() - got_q.size();
    endfunction

    // model: accepted byte if room, else sticky overflow; marker clears per byte
    task automatic model_push(input logic [7:0] b);
        if (occ() < DEPTH) exp_q.push_back({m_first, b});
        else               m_ovf = 1'b1;
        m_first = 1'b0;
    endtask

    task automatic cs_low();
        cs_n     = 1'b0;
        in_frame = 1'b1;
        m_first  = 1'b1;
        if (occ() == 0) m_ovf = 1'b0;
        miso_exp = {m_ovf, st[6:0]};
    endtask

    task automatic cs_high();
        repeat (PH) @(negedge clk);
        cs_n = 1'b1;
        if (in_frame) exp_fe++;
        in_frame = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // nbits of tx MSB first; pop_last pulses i_ready in the cycle the
    // completed byte reaches the FIFO
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit pop_last);
        logic [7:0] rx;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (PH) @(negedge clk);
            rx[7-i] = o_spi_miso;
            sclk = 1'b1;
            if (pop_last && i == 7) begin
                repeat (PH-1) @(negedge clk);
                rdy = 1'b1;
                @(negedge clk);
                rdy = 1'b0;
            end else begin
                repeat (PH) @(negedge clk);
            end
            sclk = 1'b0;
        end
        if (nbits == 8 && in_frame) begin
            if (chk_miso) check("miso_byte", 32'(rx), 32'(miso_exp));
            model_push(tx);
            miso_exp = {m_ovf, st[6:0]};
        end
    endtask

    task automatic drain_check(input string tag);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (16) @(negedge clk);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_entry"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; rdy = 1'b0; st = 8'h12;
        repeat (3) @(negedge clk);
        check("rst_miso",  32'(o_spi_miso),  0);
        check("rst_data",  32'(o_data),      0);
        check("rst_valid", 32'(o_valid),     0);
        check("rst_first", 32'(o_first),     0);
        check("rst_fe",    32'(o_frame_end), 0);
        check("rst_ovf",   32'(o_overflow),  0);
        check("rst_active",32'(o_active),    0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_active", 32'(o_active), 0);

        // two bytes, status 0x12 back
        rdy = 1'b1; st = 8'h12;
        cs_low(); xfer(8'hA5, 8, 0); xfer(8'h3C, 8, 0); cs_high();
        drain_check("t1");
        check("t1_frame_end", 32'(fe_cnt), 32'(exp_fe));

        // aborted partial byte, then a fresh frame
        st = 8'($urandom);
        cs_low(); xfer(8'hFF, 5, 0); cs_high();
        drain_check("t2_partial");
        b = 8'($urandom);
        cs_low(); xfer(b, 8, 0); cs_high();
        drain_check("t2");
        check("t2_frame_end", 32'(fe_cnt), 32'(exp_fe));

        // overflow with consumer stalled
        rdy = 1'b0; st = 8'($urandom);
        cs_low();
        for (int i = 0; i < 10; i++) xfer(8'(i), 8, 0);
        cs_high();
        repeat (8) @(negedge clk);
        check("t3_no_pop", 32'(got_q.size()), 0);
        check("t3_valid",  32'(o_valid), 1);
        check("t3_ovf",    32'(o_overflow), 32'(m_ovf));
        check("t3_head",   32'({o_first, o_data}), 32'(exp_q[0]));
        rdy = 1'b1;
        drain_check("t3");
        check("t3_ovf_sticky", 32'(o_overflow), 32'(m_ovf));
        chk_miso = 1'b0;
        cs_low(); xfer(8'($urandom), 8, 0); cs_high();
        chk_miso = 1'b1;
        drain_check("t3_after");
        check("t3_ovf_clr", 32'(o_overflow), 32'(m_ovf));

        // full FIFO with push and pop in the same cycle
        rdy = 1'b0; st = 8'($urandom);
        cs_low();
        for (int i = 0; i < DEPTH; i++) xfer(8'($urandom), 8, 0);
        xfer(8'($urandom), 8, 1);
        cs_high();
        check("t4_ovf", 32'(o_overflow), 32'(m_ovf));
        rdy = 1'b1;
        drain_check("t4");

        // asynchronous reset mid-frame
        rdy = 1'b0; st = 8'($urandom);
        cs_low(); xfer(8'($urandom), 8, 0); xfer(8'($urandom), 4, 0);
        check("t5_pre_valid",  32'(o_valid), 1);
        check("t5_pre_active", 32'(o_active), 1);
        #3 rst = 1'b1;
        #1 check("t5_async_zero",
                 32'({o_spi_miso, o_data, o_valid, o_first, o_frame_end, o_overflow, o_active}), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); got_q.delete(); m_ovf = 1'b0; in_frame = 1'b0;
        xfer(8'($urandom), 4, 0); xfer(8'($urandom), 8, 0);
        cs_high();
        check("t5_ignored_valid", 32'(o_valid), 0);
        check("t5_ignored_fe", 32'(fe_cnt), 32'(exp_fe));
        rdy = 1'b1;
        cs_low(); xfer(8'h5A, 8, 0); cs_high();
        drain_check("t5");

        // back-to-back frames, 4-cycle CS gap
        st = 8'($urandom);
        cs_low(); xfer(8'($urandom), 8, 0); cs_high();
        cs_low(); xfer(8'($urandom), 8, 0); cs_high();
        drain_check("t6");
        check("t6_frame_end", 32'(fe_cnt), 32'(exp_fe));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
